sys_bridge: RTL and testbench
=============================

Name: sys_bridge

Overview:
- Memory-mapped system bridge between two bus masters and the data-side slaves.
- Masters: CPU M-stage data port (A) and a secondary DMA-style port (B). Slaves: data memory, timer0, timer1 and the interrupt-generator response register.
- Arbitrates one access per cycle with starvation protection, decodes the address, gates write strobes, and returns all read data exactly one cycle after grant with a valid pulse to the owning master.

Parameters:
STARVE_LIMIT, 4, consecutive losing cycles of B after which B wins the next conflict
CNT_W, 3, width of starvation counter; must hold STARVE_LIMIT

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
a_req  input  1  CPU access request (load or store)
a_we  input  1  CPU write (1) / read (0)
a_addr  input  32  CPU byte address
a_wdata  input  32  CPU write data, already lane-shifted
a_byteen  input  4  CPU byte enables (0000 on reads)
a_stall  output  1  CPU must hold request this cycle
a_rvalid  output  1  CPU read/ack return valid
b_req  input  1  B request
b_we  input  1  B write/read
b_addr  input  32  B byte address
b_wdata  input  32  B write data
b_byteen  input  4  B byte enables
b_gnt  output  1  B request accepted this cycle
b_rvalid  output  1  B return valid
rdata  output  32  shared read return data
dm_addr  output  32  DM byte address
dm_wdata  output  32  DM write data
dm_byteen  output  4  DM byte write enables
dm_rdata  input  32  DM synchronous read data (valid cycle after address)
tc0_addr  output  30  timer0 word address
tc0_we  output  1  timer0 write strobe
tc0_rdata  input  32  timer0 combinational read data
tc1_addr  output  30  timer1 word address
tc1_we  output  1  timer1 write strobe
tc1_rdata  input  32  timer1 combinational read data
tc_wdata  output  32  shared timer write data
int_resp  output  1  interrupt-generator acknowledge pulse

Behaviour:
- Address map (inclusive): DM 0x0000_0000–0x0000_2FFF; timer0 0x7F00–0x7F0B; timer1 0x7F10–0x7F1B; INT 0x7F20–0x7F23; anything else is unmapped.
- Arbitration, same cycle T:
  - Only one master requesting: it wins.
  - Both requesting: A wins unless starve_cnt == STARVE_LIMIT, in which case B wins.
  - a_stall = a_req & B-granted. b_gnt = B-granted.
- starve_cnt:
  - Increments, saturating, each cycle b_req=1 and B loses.
  - Cleared to 0 on B grant or when b_req=0.
- Strobes in cycle T, from the granted request only:
  - DM hit: dm_byteen = byteen if we, else 0000. dm_addr and dm_wdata are always driven from the winner, or A when idle.
  - Timer hit: tcN_we=1 only if we & byteen==1111. Partial-word timer writes are silently dropped.
  - INT hit: int_resp=1 on a write with byteen≠0000.
  - Unmapped: no strobe, no side effect.
- Registered state at the T→T+1 edge:
  - owner_q (A/B).
  - sel_q (DM/T0/T1/INT/NONE).
  - pend_q = grant happened.
  - tc_q = captured timer read data.
- Return at T+1:
  - a_rvalid = pend_q & owner_q==A. b_rvalid = pend_q & owner_q==B.
  - Returns pulse for writes too, acting as an ack.
  - rdata = dm_rdata (DM), tc_q (T0/T1), 0 (INT/NONE). rdata = 0 when pend_q=0.
- Back-to-back grants every cycle are legal; latency is always exactly 1.
- Reset:
  - Clears starve_cnt, owner_q, sel_q, pend_q and tc_q.
  - Strobes and stall are combinational; they are 0 while no request is present.
  - Reset asserted in the cycle after a grant suppresses that return (no rvalid).

Decomposition:
- Shared package `bridge_pkg`:
  - Address-range constants, identical to the DU memory-map constants.
  - Slave-select enum (SEL_DM, SEL_T0, SEL_T1, SEL_INT, SEL_NONE).
  - Owner encoding.
- One sub-module `addr_decode`: a combinational address→select decoder used for the granted address. The DU shares the same constants.

Test Plan:
- Reset, then A read 0x0000_0010 with DM returning 0xDEADBEEF next cycle -> a_rvalid=1 at T+1, rdata=0xDEADBEEF, b_rvalid=0.
- A sw 0x7F04 (byteen 1111, data 5) -> tc0_we=1, tc0_addr=0x1FC1, tc_wdata=5. Then A sb 0x7F14 -> tc1_we=0, a_rvalid still pulses.
- Continuous A and B conflicting requests, STARVE_LIMIT=4 -> A granted 4 cycles, B granted the 5th (a_stall=1 there), counter cleared, pattern repeats.
- B read 0x7F18 with tc1_rdata=0x1234 -> b_gnt=1 at T, b_rvalid=1 and rdata=0x1234 at T+1.
- A write 0x7F20 byteen 0001 -> int_resp=1 for one cycle. A read 0x0000_5000 -> no strobes, a_rvalid=1, rdata=0.
- Grant at T, reset=1 at T+1 -> no rvalid at T+1, starve_cnt=0 afterwards.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared memory-map constants and encodings for the data-side bridge.
// Address ranges are inclusive and match the decode stage's map.
package bridge_pkg;

    localparam logic [31:0] DM_LO  = 32'h0000_0000;
    localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
    localparam logic [31:0] T0_LO  = 32'h0000_7F00;
    localparam logic [31:0] T0_HI  = 32'h0000_7F0B;
    localparam logic [31:0] T1_LO  = 32'h0000_7F10;
    localparam logic [31:0] T1_HI  = 32'h0000_7F1B;
    localparam logic [31:0] INT_LO = 32'h0000_7F20;
    localparam logic [31:0] INT_HI = 32'h0000_7F23;

    typedef enum logic [2:0] {
        SEL_DM,
        SEL_T0,
        SEL_T1,
        SEL_INT,
        SEL_NONE
    } sel_e;

    typedef enum logic {
        OWN_A,
        OWN_B
    } owner_e;

    function automatic logic in_rng(
        input logic [31:0] a,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/sys_bridge_addr_decode.sv
// Combinational address-to-slave decoder.
// Ranges never overlap, so at most one arm can match.
import bridge_pkg::*;

module addr_decode (
    input  logic [31:0] addr,
    output sel_e        sel
);

    // Map the granted byte address onto one slave select
    always_comb begin
        sel = SEL_NONE;
        unique case (1'b1)
            in_rng(addr, DM_LO, DM_HI):   sel = SEL_DM;
            in_rng(addr, T0_LO, T0_HI):   sel = SEL_T0;
            in_rng(addr, T1_LO, T1_HI):   sel = SEL_T1;
            in_rng(addr, INT_LO, INT_HI): sel = SEL_INT;
            default:                      sel = SEL_NONE;
        endcase
    end

endmodule

// File: rtl/sys_bridge.sv
// Two-master data-side bridge: arbitration with starvation guard,
// decode, strobe gating and a fixed one-cycle return path.
import bridge_pkg::*;

module sys_bridge #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_byteen,
    output logic        a_stall,
    output logic        a_rvalid,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_byteen,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata,
    output logic [29:0] tc0_addr,
    output logic        tc0_we,
    input  logic [31:0] tc0_rdata,
    output logic [29:0] tc1_addr,
    output logic        tc1_we,
    input  logic [31:0] tc1_rdata,
    output logic [31:0] tc_wdata,
    output logic        int_resp
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;
    owner_e           owner_q, owner_d;
    sel_e             sel_q, sel_d;
    logic             pend_q, pend_d;
    logic [31:0]      tc_q, tc_d;

    logic        b_win;
    logic        grant;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_be;
    sel_e        win_sel;

    addr_decode u_dec (
        .addr (win_addr),
        .sel  (win_sel)
    );

    // Pick the winner; B only beats A once it has starved long enough
    always_comb begin
        b_win     = b_req & (~a_req | (starve_q == LIM));
        grant     = a_req | b_req;
        win_we    = b_win ? b_we     : a_we;
        win_addr  = b_win ? b_addr   : a_addr;
        win_wdata = b_win ? b_wdata  : a_wdata;
        win_be    = b_win ? b_byteen : a_byteen;
        a_stall   = a_req & b_win;
        b_gnt     = b_win;
    end

    // Slave strobes come from the granted request only
    always_comb begin
        dm_addr   = win_addr;
        dm_wdata  = win_wdata;
        tc0_addr  = win_addr[31:2];
        tc1_addr  = win_addr[31:2];
        tc_wdata  = win_wdata;
        dm_byteen = '0;
        tc0_we    = 1'b0;
        tc1_we    = 1'b0;
        int_resp  = 1'b0;
        if (grant && win_we) begin
            unique case (win_sel)
                SEL_DM:  dm_byteen = win_be;
                SEL_T0:  tc0_we    = (win_be == 4'hF);
                SEL_T1:  tc1_we    = (win_be == 4'hF);
                SEL_INT: int_resp  = |win_be;
                default: ;
            endcase
        end
    end

    // Next-state for the return slot and the starvation counter
    always_comb begin
        pend_d  = grant;
        owner_d = b_win ? OWN_B : OWN_A;
        sel_d   = win_sel;
        tc_d    = tc_q;
        if (grant) begin
            unique case (win_sel)
                SEL_T0:  tc_d = tc0_rdata;
                SEL_T1:  tc_d = tc1_rdata;
                default: tc_d = '0;
            endcase
        end
        if (!b_req || b_win) begin
            starve_d = '0;
        end else if (starve_q != LIM) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            owner_q  <= OWN_A;
            sel_q    <= SEL_NONE;
            pend_q   <= 1'b0;
            tc_q     <= '0;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            tc_q     <= tc_d;
        end
    end

    // Return path one cycle after grant; reset kills an in-flight return
    always_comb begin
        a_rvalid = pend_q & ~reset & (owner_q == OWN_A);
        b_rvalid = pend_q & ~reset & (owner_q == OWN_B);
        rdata    = '0;
        if (pend_q && !reset) begin
            unique case (sel_q)
                SEL_DM:         rdata = dm_rdata;
                SEL_T0, SEL_T1: rdata = tc_q;
                default:        rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bridge.sv
// Bench for sys_bridge: per-cycle reference model plus directed
// vectors with hand-computed values.
module tb_sys_bridge;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_byteen;
    logic        a_stall, a_rvalid;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_byteen;
    logic        b_gnt, b_rvalid;
    logic [31:0] rdata;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_byteen;
    logic [29:0] tc0_addr, tc1_addr;
    logic        tc0_we, tc1_we;
    logic [31:0] tc0_rdata, tc1_rdata, tc_wdata;
    logic        int_resp;

    int tests = 0;
    int fails = 0;

    sys_bridge #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_byteen(a_byteen),
        .a_stall(a_stall), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_byteen(b_byteen),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_byteen(dm_byteen), .dm_rdata(dm_rdata),
        .tc0_addr(tc0_addr), .tc0_we(tc0_we), .tc0_rdata(tc0_rdata),
        .tc1_addr(tc1_addr), .tc1_we(tc1_we), .tc1_rdata(tc1_rdata),
        .tc_wdata(tc_wdata), .int_resp(int_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Region from the memory map: 0 DM, 1 T0, 2 T1, 3 INT, 4 none
    function automatic int region(input logic [31:0] a);
        if (a <= 32'h2FFF) return 0;
        if (a >= 32'h7F00 && a <= 32'h7F0B) return 1;
        if (a >= 32'h7F10 && a <= 32'h7F1B) return 2;
        if (a >= 32'h7F20 && a <= 32'h7F23) return 3;
        return 4;
    endfunction

    // Model state: one pending return and the loss count of B
    bit          m_v = 0;
    bit          m_b = 0;
    int          m_k = 4;
    logic [31:0] m_tc = '0;
    int          m_starve = 0;

    bit          e_bw, e_g, e_we;
    logic [31:0] e_a, e_d, e_rd;
    logic [3:0]  e_be;
    int          e_k;

    always @(negedge clk) begin
        e_bw = b_req && (!a_req || m_starve >= LIMIT);
        e_g  = a_req || b_req;
        e_a  = e_bw ? b_addr : a_addr;
        e_d  = e_bw ? b_wdata : a_wdata;
        e_we = e_bw ? b_we : a_we;
        e_be = e_bw ? b_byteen : a_byteen;
        e_k  = region(e_a);
        chk("m_b_gnt", 32'(b_gnt), 32'(e_bw));
        chk("m_a_stall", 32'(a_stall), 32'(a_req && e_bw));
        chk("m_dm_addr", dm_addr, e_a);
        chk("m_dm_wdata", dm_wdata, e_d);
        chk("m_tc_wdata", tc_wdata, e_d);
        chk("m_tc0_addr", 32'(tc0_addr), e_a >> 2);
        chk("m_tc1_addr", 32'(tc1_addr), e_a >> 2);
        chk("m_dm_byteen", 32'(dm_byteen),
            (e_g && e_k == 0 && e_we) ? 32'(e_be) : 32'd0);
        chk("m_tc0_we", 32'(tc0_we),
            32'(e_g && e_k == 1 && e_we && e_be == 4'hF));
        chk("m_tc1_we", 32'(tc1_we),
            32'(e_g && e_k == 2 && e_we && e_be == 4'hF));
        chk("m_int_resp", 32'(int_resp),
            32'(e_g && e_k == 3 && e_we && e_be != 4'h0));
        chk("m_a_rvalid", 32'(a_rvalid), 32'(m_v && !reset && !m_b));
        chk("m_b_rvalid", 32'(b_rvalid), 32'(m_v && !reset && m_b));
        e_rd = 32'd0;
        if (m_v && !reset) begin
            if (m_k == 0) e_rd = dm_rdata;
            else if (m_k == 1 || m_k == 2) e_rd = m_tc;
        end
        chk("m_rdata", rdata, e_rd);
        if (reset) begin
            m_v = 0; m_b = 0; m_k = 4; m_tc = '0; m_starve = 0;
        end else begin
            m_v  = e_g;
            m_b  = e_bw;
            m_k  = e_k;
            m_tc = (e_k == 1) ? tc0_rdata :
                   (e_k == 2) ? tc1_rdata : 32'd0;
            if (!b_req || e_bw) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_a(input logic r, input logic w,
                         input logic [31:0] ad, input logic [31:0] d,
                         input logic [3:0] be);
        a_req = r; a_we = w; a_addr = ad; a_wdata = d; a_byteen = be;
    endtask

    task automatic set_b(input logic r, input logic w,
                         input logic [31:0] ad, input logic [31:0] d,
                         input logic [3:0] be);
        b_req = r; b_we = w; b_addr = ad; b_wdata = d; b_byteen = be;
    endtask

    logic [9:0] pat10;
    logic [4:0] pat5;

    initial begin
        reset = 1'b1;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        dm_rdata = '0; tc0_rdata = '0; tc1_rdata = '0;
        pat10 = 10'b10000_10000;
        pat5  = 5'b10000;
        repeat (2) nxt();
        reset = 1'b0;
        mid();
        chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        // A read from DM
        nxt(); set_a(1, 0, 32'h10, 0, 4'h0);
        mid();
        chk("rd_stall", 32'(a_stall), 32'd0);
        chk("rd_dm_addr", dm_addr, 32'h10);
        nxt(); set_a(0, 0, 0, 0, 0); dm_rdata = 32'hDEADBEEF;
        mid();
        chk("rd_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        chk("rd_b_rvalid", 32'(b_rvalid), 32'd0);

        // Timer full-word write, then a dropped byte write
        nxt(); set_a(1, 1, 32'h7F04, 32'd5, 4'hF); dm_rdata = '0;
        mid();
        chk("sw_tc0_we", 32'(tc0_we), 32'd1);
        chk("sw_tc0_addr", 32'(tc0_addr), 32'h1FC1);
        chk("sw_tc_wdata", tc_wdata, 32'd5);
        nxt(); set_a(1, 1, 32'h7F14, 32'd7, 4'h1);
        mid();
        chk("sb_tc1_we", 32'(tc1_we), 32'd0);
        chk("sw_ack", 32'(a_rvalid), 32'd1);
        nxt(); set_a(0, 0, 0, 0, 0);
        mid();
        chk("sb_ack", 32'(a_rvalid), 32'd1);

        // Continuous conflict: B wins every fifth cycle
        for (int i = 0; i < 10; i++) begin
            nxt();
            set_a(1, 0, 32'h100, 0, 4'h0);
            set_b(1, 0, 32'h200, 0, 4'h0);
            mid();
            chk($sformatf("arb_gnt%0d", i), 32'(b_gnt), 32'(pat10[i]));
            chk($sformatf("arb_stall%0d", i), 32'(a_stall),
                32'(pat10[i]));
        end

        // B reads timer1; data captured at grant
        nxt(); set_a(0, 0, 0, 0, 0);
        set_b(1, 0, 32'h7F18, 0, 4'h0); tc1_rdata = 32'h1234;
        mid();
        chk("t1_b_gnt", 32'(b_gnt), 32'd1);
        nxt(); set_b(0, 0, 0, 0, 0); tc1_rdata = 32'hFFFF;
        mid();
        chk("t1_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("t1_rdata", rdata, 32'h1234);
        chk("t1_a_rvalid", 32'(a_rvalid), 32'd0);

        // Interrupt ack, then an unmapped read
        nxt(); set_a(1, 1, 32'h7F20, 32'd1, 4'h1); tc1_rdata = '0;
        mid();
        chk("int_resp1", 32'(int_resp), 32'd1);
        nxt(); set_a(1, 0, 32'h5000, 0, 4'h0); dm_rdata = 32'hCAFEF00D;
        mid();
        chk("int_resp0", 32'(int_resp), 32'd0);
        chk("um_byteen", 32'(dm_byteen), 32'd0);
        nxt(); set_a(0, 0, 0, 0, 0);
        mid();
        chk("um_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("um_rdata", rdata, 32'd0);

        // Build up starvation, then reset right after a grant
        for (int i = 0; i < 3; i++) begin
            nxt();
            set_a(1, 0, 32'h40, 0, 4'h0);
            set_b(1, 0, 32'h80, 0, 4'h0);
        end
        nxt(); reset = 1'b1;
        mid();
        chk("rst_ret_a", 32'(a_rvalid), 32'd0);
        chk("rst_ret_b", 32'(b_rvalid), 32'd0);
        nxt(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nxt();
            mid();
            chk($sformatf("post_rst_gnt%0d", i), 32'(b_gnt),
                32'(pat5[i]));
        end
        nxt(); set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
        repeat (3) nxt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
